tree_run_ctrl: RTL and testbench

//  Upstream/downstream controller for a generated root_* evaluation tree.

---
 rtl/tree_ctrl_pkg.sv | 21 ++
 rtl/tree_operand_bank.sv | 39 +++
 rtl/tree_run_ctrl.sv | 145 ++++++++++++++
 tb/tb_tree_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_ctrl_pkg.sv
// Shared definitions for the evaluation-tree run controller and the generated
// root_* wrappers that sit beside it.
package tree_ctrl_pkg;

    // Controller phases: collect operands, wait on the tree, present result
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Default operand width and operand count of the generated trees
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NARGS = 5;

    // Index width that stays legal for a single-operand tree
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tree_operand_bank.sv
// NARGS x WIDTH operand registers with an indexed write port. The flattened
// bus feeds the tree's IN0..IN(N-1) directly.
module tree_operand_bank
    import tree_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NARGS = DEF_NARGS,
    parameter int IDXW  = idx_bits(DEF_NARGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_we,
    input  logic [IDXW-1:0]        i_idx,
    input  logic [WIDTH-1:0]       i_data,
    output logic [NARGS*WIDTH-1:0] o_ops
);

    genvar gi;
    generate
        for (gi = 0; gi < NARGS; gi++) begin : g_slot
            logic [WIDTH-1:0] r_slot;
            logic             w_sel;

            assign w_sel = i_we && (i_idx == IDXW'(gi));

            // Slot gi captures the incoming word only when it is the addressed slot
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_slot <= '0;
                end else if (w_sel) begin
                    r_slot <= i_data;
                end
            end

            assign o_ops[gi*WIDTH +: WIDTH] = r_slot;
        end
    endgenerate

endmodule

// File: rtl/tree_run_ctrl.sv
// Run controller for a root_* evaluation tree: gathers NARGS operands from a
// valid/ready stream, holds ST while the tree evaluates, captures RES on RD
// (or flags a timeout), and returns the outcome on a valid/ready result port.
module tree_run_ctrl
    import tree_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NARGS   = DEF_NARGS,
    parameter int TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    input  logic [WIDTH-1:0]       i_in_data,
    output logic                   o_in_ready,
    output logic [NARGS*WIDTH-1:0] o_ops,
    output logic                   o_tst,
    input  logic                   i_trd,
    input  logic [WIDTH-1:0]       i_tres,
    output logic                   o_out_valid,
    output logic [WIDTH-1:0]       o_out_data,
    output logic                   o_out_err,
    input  logic                   i_out_ready,
    output logic                   o_busy
);

    localparam int IDXW = idx_bits(NARGS);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NARGS - 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_ONE = TW'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [TW-1:0]     r_timer;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_err;

    logic              w_accept;
    logic              w_launch;
    logic              w_capture;
    logic              w_timeout;
    logic              w_release;

    // An operand is taken whenever LOAD sees valid; the last one launches the tree
    assign w_accept  = (r_state == ST_LOAD) && i_in_valid;
    assign w_launch  = w_accept && (r_idx == IDX_LAST);
    // RUN cycle 1 (timer==1) ignores RD, which may still be high from the previous run
    assign w_capture = (r_state == ST_RUN) && i_trd && (r_timer != TIMER_ONE);
    // A same-cycle capture takes priority over the timeout
    assign w_timeout = (r_state == ST_RUN) && !w_capture && (r_timer == TIMER_MAX);
    assign w_release = (r_state == ST_OUT) && i_out_ready;

    tree_operand_bank #(
        .WIDTH (WIDTH),
        .NARGS (NARGS),
        .IDXW  (IDXW)
    ) u_bank (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_accept),
        .i_idx  (r_idx),
        .i_data (i_in_data),
        .o_ops  (o_ops)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: if (w_launch)                w_state_next = ST_RUN;
            ST_RUN:  if (w_capture || w_timeout)  w_state_next = ST_OUT;
            ST_OUT:  if (i_out_ready)             w_state_next = ST_LOAD;
            default:                              w_state_next = ST_LOAD;
        endcase
    end

    // Outputs decoded from state only, so a reset drops ST without waiting for a clock
    always_comb begin
        o_in_ready  = 1'b0;
        o_tst       = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_LOAD: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
            end
            ST_RUN:  o_tst       = 1'b1;
            ST_OUT:  o_out_valid = 1'b1;
            default: o_busy      = 1'b1;
        endcase
    end

    // Operand slot pointer wraps to 0 on the launching accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // RUN-cycle counter: 1 on the first RUN cycle, saturating at TIMEOUT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_launch) begin
            r_timer <= TIMER_ONE;
        end else if ((r_state == ST_RUN) && (r_timer != TIMER_MAX)) begin
            r_timer <= r_timer + 1'b1;
        end else if (w_release) begin
            r_timer <= '0;
        end
    end

    // Result register: RES on capture, zero plus error flag on timeout, else held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else if (w_capture) begin
            r_out_data <= i_tres;
            r_out_err  <= 1'b0;
        end else if (w_timeout) begin
            r_out_data <= '0;
            r_out_err  <= 1'b1;
        end
    end

    assign o_out_data = r_out_data;
    assign o_out_err  = r_out_err;

endmodule

// File: tb/tb_tree_run_ctrl.sv
// Directed bench for tree_run_ctrl with a stub tree: the stub raises RD after
// a fixed number of ST-high cycles and returns the sum of its operands, or can
// be told never to answer, or to hold a stale RD with a fixed RES.
`timescale 1ns/1ps
module tb_tree_run_ctrl;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int TO = 8;
    localparam int D  = 3;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [N*W-1:0] ops;
    logic           tst;
    logic           trd;
    logic [W-1:0]   tres;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_err;
    logic           out_ready;
    logic           busy;

    int tests;
    int fails;

    // 0: RD after D ST-high cycles, RES = sum; 1: never RD; 2: RD stuck high, RES = 0xABCD
    int        stub_mode;
    logic [7:0] st_cnt;

    tree_run_ctrl #(.WIDTH(W), .NARGS(N), .TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_ops       (ops),
        .o_tst       (tst),
        .i_trd       (trd),
        .i_tres      (tres),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_err   (out_err),
        .i_out_ready (out_ready),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub tree: count cycles of ST high, restart whenever ST is low
    always @(posedge clk or posedge rst) begin
        if (rst)      st_cnt <= '0;
        else if (tst) st_cnt <= st_cnt + 8'd1;
        else          st_cnt <= '0;
    end

    always_comb begin
        logic [W-1:0] sum;
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + ops[k*W +: W];
        trd  = 1'b0;
        tres = sum;
        case (stub_mode)
            0: trd = tst && (st_cnt >= 8'(D));
            1: trd = 1'b0;
            2: begin trd = 1'b1; tres = 16'hABCD; end
            default: trd = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [W-1:0] w, input int gap);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        load_word(16'h0011, 0);
        load_word(16'h0022, 0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (tst !== 1'b0 || out_valid !== 1'b0 || ops !== '0 || out_data !== '0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: tst=%b out_valid=%b ops=%h out_data=%h out_err=%b, want 0 0 0 0 0",
                     tst, out_valid, ops, out_data, out_err);
        end
        @(posedge clk); #1 rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_nominal();
        int n;
        stub_mode = 0;
        load_word(16'd1, 0);
        load_word(16'd2, 1);
        load_word(16'd3, 2);
        load_word(16'd4, 0);
        repeat (1) tick();
        tests++;
        if (tst !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL nominal_pre_launch: tst=%b in_ready=%b, want 0 1", tst, in_ready);
        end
        load_word(16'd5, 0);
        tests++;
        if (tst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL nominal_launch: tst=%b in_ready=%b busy=%b, want 1 0 1", tst, in_ready, busy);
        end
        tests++;
        if (ops !== {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}) begin
            fails++;
            $display("FAIL nominal_ops: ops=%h, want 00050004000300020001", ops);
        end
        n = 0;
        while (tst === 1'b1 && n < 50) begin tick(); n++; end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL nominal_run_len: tst high %0d cycles, want 4", n);
        end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h000F || out_err !== 1'b0) begin
            fails++;
            $display("FAIL nominal_result: valid=%b data=%h err=%b, want 1 000f 0", out_valid, out_data, out_err);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 16'h000F || out_err !== 1'b0 || in_ready !== 1'b0 || tst !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h err=%b in_ready=%b tst=%b, want 1 000f 0 0 0",
                         c, out_valid, out_data, out_err, in_ready, tst);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL handshake_release: valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        tick();
        tests++;
        if (ops !== {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}) begin
            fails++;
            $display("FAIL handshake_no_accept: ops=%h, want 00050004000300020001", ops);
        end
    endtask

    task automatic test_timeout();
        int n;
        stub_mode = 1;
        for (int k = 1; k <= N; k++) load_word(16'(10 * k), 0);
        n = 0;
        while (tst === 1'b1 && n < 50) begin tick(); n++; end
        tests++;
        if (n != TO) begin
            fails++;
            $display("FAIL timeout_run_len: tst high %0d cycles, want %0d", n, TO);
        end
        tests++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 16'h0000) begin
            fails++;
            $display("FAIL timeout_result: valid=%b err=%b data=%h, want 1 1 0000", out_valid, out_err, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_stale_rd();
        int n;
        stub_mode = 2;
        for (int k = 1; k <= N; k++) load_word(16'(k), 0);
        n = 0;
        while (tst === 1'b1 && n < 50) begin tick(); n++; end
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL stale_run_len: tst high %0d cycles, want 2", n);
        end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'hABCD || out_err !== 1'b0) begin
            fails++;
            $display("FAIL stale_result: valid=%b data=%h err=%b, want 1 abcd 0", out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        stub_mode = 0;
        tick();
    endtask

    task automatic test_rst_midrun();
        int n;
        stub_mode = 0;
        for (int k = 0; k < N; k++) load_word(16'(100 + k), 0);
        tick(); tick(); tick();
        tests++;
        if (tst !== 1'b1) begin
            fails++;
            $display("FAIL midrun_in_run: tst=%b, want 1", tst);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (tst !== 1'b0 || ops !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: tst=%b ops=%h valid=%b, want 0 0 0", tst, ops, out_valid);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < N; k++) load_word(16'(7 + k), 0);
        tests++;
        if (ops !== {16'd11, 16'd10, 16'd9, 16'd8, 16'd7} || tst !== 1'b1) begin
            fails++;
            $display("FAIL midrun_reload: ops=%h tst=%b, want 000b000a000900080007 1", ops, tst);
        end
        n = 0;
        while (tst === 1'b1 && n < 50) begin tick(); n++; end
        tests++;
        if (n != 4 || out_valid !== 1'b1 || out_data !== 16'h002D || out_err !== 1'b0) begin
            fails++;
            $display("FAIL midrun_result: run=%0d valid=%b data=%h err=%b, want 4 1 002d 0",
                     n, out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        stub_mode = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_stale_rd();
        test_rst_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion before 100us");
        $fatal(1, "watchdog expired");
    end

endmodule
